fir_serial_ctrl: RTL and testbench



---
 rtl/fir_serial_pkg.sv | 32 +++
 rtl/fir_sample_buf.sv | 31 +++
 rtl/fir_serial_ctrl.sv | 151 +++++++++++++++
 tb/tb_fir_serial_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_serial_pkg.sv
// Shared types and the output scaling helper for the serial FIR sequencer.
package fir_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  localparam int SAT_W = 128;

  // Floor-shift a Q(2*dw-2) accumulator back to Q1.(dw-1) and clamp to dw bits.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      dw
  );
    logic signed [SAT_W-1:0] shifted_s;
    logic signed [SAT_W-1:0] max_s;
    logic signed [SAT_W-1:0] min_s;
    shifted_s = acc >>> (dw - 1);
    max_s     = (128'sd1 <<< (dw - 1)) - 128'sd1;
    min_s     = -max_s - 128'sd1;
    if (shifted_s > max_s) begin
      sat_shift = max_s;
    end else if (shifted_s < min_s) begin
      sat_shift = min_s;
    end else begin
      sat_shift = shifted_s;
    end
  endfunction

endpackage

// File: rtl/fir_sample_buf.sv
// TAPS-deep sample history: synchronous write, combinational read, synchronous clear.
module fir_sample_buf #(
  parameter  int DW   = 16,
  parameter  int TAPS = 32,
  localparam int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [TAPS];

  // Storage update: clear wins over write.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < TAPS; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fir_serial_ctrl.sv
// Time-multiplexed serial FIR sequencer: one MAC per cycle over TAPS taps,
// saturated result held on a valid/ready output.
module fir_serial_ctrl
  import fir_serial_pkg::*;
#(
  parameter  int DW   = 16,
  parameter  int TAPS = 32,
  localparam int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x,
  output logic [AW-1:0] coef_addr,
  input  logic [DW-1:0] coef_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y
);

  localparam int ACCW = 2 * DW + AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

  fir_state_t              state_r;
  fir_state_t              state_nxt_s;
  logic [AW-1:0]           k_r;
  logic [AW-1:0]           wptr_r;
  logic [AW-1:0]           rptr_r;
  logic signed [ACCW-1:0]  acc_r;
  logic [DW-1:0]           y_r;
  logic                    out_valid_r;

  logic                    accept_s;
  logic                    last_s;
  logic [DW-1:0]           rdata_s;
  logic signed [2*DW-1:0]  prod_s;
  logic signed [ACCW-1:0]  acc_sum_s;
  logic [DW-1:0]           y_sat_s;
  logic [AW-1:0]           wptr_inc_s;
  logic [AW-1:0]           rptr_dec_s;

  assign accept_s   = (state_r == IDLE) && in_valid;
  assign last_s     = (k_r == LAST_IDX);
  assign prod_s     = $signed(coef_in) * $signed(rdata_s);
  assign acc_sum_s  = acc_r + ACCW'(prod_s);
  assign y_sat_s    = DW'(sat_shift(SAT_W'(acc_sum_s), DW));
  // Explicit wrap so TAPS need not be a power of two.
  assign wptr_inc_s = (wptr_r == LAST_IDX) ? {AW{1'b0}} : wptr_r + {{(AW-1){1'b0}}, 1'b1};
  assign rptr_dec_s = (rptr_r == {AW{1'b0}}) ? LAST_IDX : rptr_r - {{(AW-1){1'b0}}, 1'b1};

  fir_sample_buf #(
    .DW   (DW),
    .TAPS (TAPS)
  ) u_buf (
    .clk   (clk),
    .clr_n (rst_n),
    .we    (accept_s),
    .waddr (wptr_r),
    .wdata (x),
    .raddr (rptr_r),
    .rdata (rdata_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = MAC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MAC: begin
        if (last_s) begin
          state_nxt_s = OUT;
        end else begin
          state_nxt_s = MAC;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath: pointers, tap counter, accumulator and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_r         <= {AW{1'b0}};
      wptr_r      <= {AW{1'b0}};
      rptr_r      <= {AW{1'b0}};
      acc_r       <= {ACCW{1'b0}};
      y_r         <= {DW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            rptr_r <= wptr_r;
            wptr_r <= wptr_inc_s;
            k_r    <= {AW{1'b0}};
            acc_r  <= {ACCW{1'b0}};
          end
        end
        MAC: begin
          acc_r  <= acc_sum_s;
          rptr_r <= rptr_dec_s;
          // k returns to 0 on exit so coef_addr reads 0 outside MAC.
          if (last_s) begin
            k_r         <= {AW{1'b0}};
            y_r         <= y_sat_s;
            out_valid_r <= 1'b1;
          end else begin
            k_r <= k_r + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign coef_addr = k_r;
  assign out_valid = out_valid_r;
  assign y         = y_r;

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Directed and model-checked bench for fir_serial_ctrl with TAPS=4, DW=16.
module tb_fir_serial_ctrl;

  localparam int DW   = 16;
  localparam int TAPS = 4;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] x = 16'd0;
  logic [AW-1:0] coef_addr;
  logic [DW-1:0] coef_in;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] y;

  logic signed [DW-1:0] coef_rom [TAPS];
  logic signed [DW-1:0] hist [TAPS];
  int checks = 0;
  int failures = 0;

  typedef struct {
    bit                   rst;
    bit                   sat;
    logic signed [DW-1:0] xv;
    bit                   chk;
    logic signed [DW-1:0] exp_y;
  } vec_t;
  vec_t tbl [13];

  always #5 clk = ~clk;

  assign coef_in = coef_rom[coef_addr];

  fir_serial_ctrl #(.DW(DW), .TAPS(TAPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .coef_addr (coef_addr),
    .coef_in   (coef_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_coefs(input bit sat);
    if (sat) begin
      for (int i = 0; i < TAPS; i++) coef_rom[i] = 16'sd32767;
    end else begin
      coef_rom[0] = 16'sd16384;
      coef_rom[1] = 16'sd8192;
      coef_rom[2] = -16'sd16384;
      coef_rom[3] = 16'sd4096;
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < TAPS; i++) hist[i] = 16'sd0;
  endtask

  task automatic push_hist(input logic signed [DW-1:0] v);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_hist();
  endtask

  function automatic logic signed [DW-1:0] model_y();
    longint acc;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(coef_rom[k]) * longint'(hist[k]);
    acc = acc >>> 15;
    if (acc > 32767) return 16'sh7fff;
    if (acc < -32768) return 16'sh8000;
    return 16'(acc);
  endfunction

  // Offer one sample, then collect its result with out_ready high.
  task automatic send_sample(input logic signed [DW-1:0] v, output logic signed [DW-1:0] got);
    int ok;
    ok = 0;
    got = 16'sd0;
    in_valid = 1'b1;
    x = v;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      if (in_ready) ok = 1;
      tick();
    end
    in_valid = 1'b0;
    check("accept", ok, 1);
    if (ok != 0) push_hist(v);
    ok = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      if (out_valid) begin
        got = $signed(y);
        ok = 1;
      end
      tick();
    end
    out_ready = 1'b0;
    check("result_seen", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [DW-1:0] got;
    logic signed [DW-1:0] exp_v;
    logic signed [DW-1:0] imp_exp [4];

    tbl[0]  = '{1'b1, 1'b0, 16'sd16384, 1'b1, 16'sd8192};
    tbl[1]  = '{1'b0, 1'b0, 16'sd0,     1'b1, 16'sd4096};
    tbl[2]  = '{1'b0, 1'b0, 16'sd0,     1'b1, -16'sd8192};
    tbl[3]  = '{1'b0, 1'b0, 16'sd0,     1'b1, 16'sd2048};
    tbl[4]  = '{1'b0, 1'b0, 16'sd0,     1'b1, 16'sd0};
    tbl[5]  = '{1'b1, 1'b1, 16'sd32767, 1'b0, 16'sd0};
    tbl[6]  = '{1'b0, 1'b1, 16'sd32767, 1'b0, 16'sd0};
    tbl[7]  = '{1'b0, 1'b1, 16'sd32767, 1'b0, 16'sd0};
    tbl[8]  = '{1'b0, 1'b1, 16'sd32767, 1'b1, 16'sd32767};
    tbl[9]  = '{1'b0, 1'b1, 16'sh8000,  1'b0, 16'sd0};
    tbl[10] = '{1'b0, 1'b1, 16'sh8000,  1'b0, 16'sd0};
    tbl[11] = '{1'b0, 1'b1, 16'sh8000,  1'b0, 16'sd0};
    tbl[12] = '{1'b0, 1'b1, 16'sh8000,  1'b1, 16'sh8000};
    imp_exp[0] = 16'sd8192;
    imp_exp[1] = 16'sd4096;
    imp_exp[2] = -16'sd8192;
    imp_exp[3] = 16'sd2048;

    set_coefs(1'b0);
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_y", $signed(y), 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_coef_addr", coef_addr, 0);

    // Latency and address sequencing: sample captured at edge 1.
    in_valid = 1'b1;
    x = 16'd16384;
    tick();
    in_valid = 1'b0;
    push_hist(16'sd16384);
    check("lat_in_ready_e1", in_ready, 0);
    check("lat_coef_e1", coef_addr, 0);
    check("lat_out_valid_e1", out_valid, 0);
    for (int k = 1; k < TAPS; k++) begin
      tick();
      check("lat_coef", coef_addr, k);
      check("lat_out_valid_low", out_valid, 0);
      check("lat_in_ready_low", in_ready, 0);
    end
    tick();
    check("lat_out_valid_e5", out_valid, 1);
    check("lat_y", $signed(y), 8192);
    check("lat_coef_out", coef_addr, 0);

    // Backpressure with a competing sample on the input.
    in_valid = 1'b1;
    x = 16'd1234;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_y", $signed(y), 8192);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    send_sample(16'sd0, got);
    check("bp_no_extra_sample", got, 4096);

    // Table-driven impulse and saturation vectors.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rst) do_reset();
      set_coefs(tbl[i].sat);
      send_sample(tbl[i].xv, got);
      if (tbl[i].chk) check($sformatf("vec%0d", i), got, tbl[i].exp_y);
    end

    // Reset during the second MAC cycle, then a clean impulse.
    set_coefs(1'b0);
    in_valid = 1'b1;
    x = 16'd32767;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_hist();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y", $signed(y), 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_coef_addr", coef_addr, 0);
    for (int i = 0; i < 4; i++) begin
      send_sample((i == 0) ? 16'sd16384 : 16'sd0, got);
      check($sformatf("midrst_imp%0d", i), got, imp_exp[i]);
    end

    // Random stream against the reference model; wraps the pointers.
    for (int i = 0; i < 10; i++) begin
      send_sample(16'($urandom), got);
      exp_v = model_y();
      check($sformatf("rand%0d", i), got, exp_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
